// File: rtl/nibble_serial_sub.sv
// ============================================================================
//  Module   : nibble_serial_sub
//  Purpose  : Nibble-serial a - b - bin over 4*NIBBLES bits, LSB nibble first.
//             Optional macro SUB_OVF_EN adds a signed-overflow output (ovf).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_sub #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int            CW         = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] c_last_nib = CW'(NIBBLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_diff;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic          r_done;
    logic          r_bout;
    logic [3:0]    w_a_nib;
    logic [3:0]    w_b_nib;
    logic [3:0]    w_d;
    logic [4:0]    w_bc;
    logic          w_accept;
    logic          w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_last_nib);

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == i[CW-1:0]) begin
                w_a_nib = r_a[i*4 +: 4];
                w_b_nib = r_b[i*4 +: 4];
            end
        end
    end

    // 4-bit ripple-borrow cell: w_bc[0] is bin, w_bc[4] is the nibble borrow-out
    assign w_bc[0] = r_borrow;
    for (genvar g = 0; g < 4; g++) begin : g_cell
        assign w_d[g]    = w_a_nib[g] ^ w_b_nib[g] ^ w_bc[g];
        assign w_bc[g+1] = (~w_a_nib[g] & w_b_nib[g])
                         | (~(w_a_nib[g] ^ w_b_nib[g]) & w_bc[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_borrow <= bin;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (r_cnt == i[CW-1:0]) begin
                        r_diff[i*4 +: 4] <= w_d;
                    end
                end
                r_borrow <= w_bc[4];
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_bout <= w_bc[4];
                end
            end
        end
    end

`ifdef SUB_OVF_EN
    logic r_ovf;

    // On the last nibble, w_d[3] is the final sign bit of diff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[W-1] != r_b[W-1]) && (w_d[3] != r_a[W-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_sub.sv
// ============================================================================
//  Module   : tb_nibble_serial_sub
//  Purpose  : Directed and random checks of nibble_serial_sub (NIBBLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_sub;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_sub #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the full-width unsigned difference with borrow in bit W
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W:0] r;
        r = ref_sub(x, y, c);
        return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Model: result known at acceptance, released NIBBLES edges later
    logic         m_busy;
    logic         m_done;
    int           m_left;
    logic [W:0]   m_res;
    logic [W-1:0] m_diff;
    logic         m_bout;
`ifdef SUB_OVF_EN
    logic         m_ovf_pend;
    logic         m_ovf;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
            m_diff <= '0;
            m_bout <= 1'b0;
`ifdef SUB_OVF_EN
            m_ovf_pend <= 1'b0;
            m_ovf      <= 1'b0;
`endif
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_left <= NIBBLES;
                    m_res  <= ref_sub(a, b, bin);
`ifdef SUB_OVF_EN
                    m_ovf_pend <= ref_ovf(a, b, bin);
`endif
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_diff <= m_res[W-1:0];
                m_bout <= m_res[W];
`ifdef SUB_OVF_EN
                m_ovf  <= m_ovf_pend;
`endif
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'b0, busy}, {31'b0, m_busy});
        check("done", {31'b0, done}, {31'b0, m_done});
        if (m_done || !m_busy) begin
            check("diff", {16'b0, diff}, {16'b0, m_diff});
            check("bout", {31'b0, bout}, {31'b0, m_bout});
`ifdef SUB_OVF_EN
            check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a     = x;
        b     = y;
        bin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic [W-1:0] ed, input logic eb);
        int lat;
        drive(x, y, c);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        wait_done(lat);
        check("latency", lat, NIBBLES);
        check("diff_lit", {16'b0, diff}, {16'b0, ed});
        check("bout_lit", {31'b0, bout}, {31'b0, eb});
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", {16'b0, diff}, 32'd0);
        check("rst_bout", {31'b0, bout}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        repeat (2) @(negedge clk);
        op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
        op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // A start pulse mid-run must be ignored
        drive(16'h1000, 16'h0001, 1'b0);
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("latency_mid", lat, 2);
        check("diff_chain", {16'b0, diff}, 32'h0FFF);
        check("bout_chain", {31'b0, bout}, 32'd0);
        // Back-to-back: start issued in the done cycle
        op(16'h0F0F, 16'h00F1, 1'b0, 16'h0E1E, 1'b0);

`ifdef SUB_OVF_EN
        op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1);
        check("ovf_set", {31'b0, ovf}, 32'd1);
        op(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0);
        check("ovf_clr", {31'b0, ovf}, 32'd0);
`endif

        // Asynchronous reset in the middle of a run
        drive(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_diff", {16'b0, diff}, 32'd0);
        check("arst_bout", {31'b0, bout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {31'b0, done}, 32'd0);
        end
        op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            bin   = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
Multi-cycle subtractor computing a − b − bin over 4·NIBBLES bits, one nibble per clock, least-significant nibble first. It feeds operand nibbles and a registered borrow into the team's 4-bit ripple-borrow subtractor cell (ports bin, A[3:0], B[3:0], D[3:0], b[4:1]). It then collects the cell's D nibble and b[4] borrow-out. Sits between the operand source and the result consumer, with a start/done handshake.

Parameters:
NIBBLES, 4, number of 4-bit digits processed; operand width W = 4·NIBBLES; legal range ≥ 1.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request; sampled only in IDLE.
a  input  W  minuend; latched on accepted start.
b  input  W  subtrahend; latched on accepted start.
bin  input  1  borrow-in to nibble 0; latched on accepted start.
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse; diff/bout valid.
diff  output  W  result, a − b − bin mod 2^W.
bout  output  1  final borrow-out: 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0, nibble counter=0, borrow register=0, operand registers=0. Any operation in flight is abandoned with no done pulse.
- States:
  - IDLE: start=1 at a rising edge latches a, b, bin (bin into borrow register), sets counter=0 and moves to RUN. busy goes high after that edge.
  - RUN: at each rising edge, nibble[counter] of the latched a/b plus the borrow register go through the 4-bit cell. D is written into diff nibble[counter] and b[4] into the borrow register, then counter increments.
  - RUN exit: at the edge processing nibble NIBBLES−1, go to IDLE, set busy=0, done=1 and bout=b[4].
- Latency: with start accepted at edge E0, done is high during the cycle following edge E_NIBBLES (NIBBLES edges after acceptance). done drops at the next edge unless a new run completes there.
- diff and bout hold their values from the last completed run until the next completion or reset. Intermediate nibbles of diff update during RUN; consumers use diff only when done=1 or in IDLE.
- start while busy=1 is ignored (not queued). Changes on a, b and bin after acceptance have no effect.
- Back-to-back: start may be high in the same cycle as done (state is IDLE), giving one result every NIBBLES+1 cycles.
- Arithmetic is unsigned modulo 2^W with no saturation. Borrow ripples across cycles only through the borrow register; no combinational path from a/b/bin to any output.
- NIBBLES=1: RUN lasts one edge, and done follows the edge after acceptance.

Optional Feature:
SUB_OVF_EN
- Defined: adds output port ovf (1 bit, reset 0), which treats a and b as two's-complement signed values. It is registered together with done/bout: ovf = (a[W−1] ≠ b[W−1]) && (diff[W−1] ≠ a[W−1]), using the latched a/b and the final diff. ovf holds like diff.
- Not defined: no ovf port and no related logic; all other behaviour is identical.

Test Plan (NIBBLES=4):
- a=0x1234, b=0x0234, bin=0, start at E0 -> busy high E1..E4, done=1 after E4, diff=0x1000, bout=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; with bin=1 and b=0x0000 -> diff=0xFFFF, bout=1.
- a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
- Borrow chain: a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0. Second start pulsed during RUN is ignored. A new start held in the done cycle is accepted, and its done follows 4 edges later.
- rst_n low after E2 of a run -> busy, done, diff and bout are 0 immediately; no done pulse follows. After release, start with a=0x0005, b=0x0003 -> diff=0x0002.
- SUB_OVF_EN defined: a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1. a=0x0003, b=0x0001 -> ovf=0.
